data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Next-generation data memory for the core's load/store path: parametrised depth, byte/halfword/word access with byte enables, sign/zero extension on loads.
- Sits between the load/store unit and a synchronous-read RAM array.
- Valid/ready request–response handshake with one outstanding transaction, which allows response backpressure.
- Replaces the single-cycle word-only combinational-read memory.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- ADDR_W, 32, request address width; must be at least clog2(DEPTH_WORDS)+2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores and word loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and error responses.
- resp_err  out  1  access fault (only with MEM_MISALIGN_TRAP_EN).

Behaviour:
- Reset: resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE.
  - RAM contents are not affected by rst; the array is zero-initialised at elaboration only.
- Word index = req_addr[clog2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH_WORDS.
- req_ready = !resp_valid || resp_ready, so a new request is accepted in the same cycle the old response drains.
- Acceptance occurs when req_valid && req_ready at the rising edge.
- State machine:
  - IDLE (resp_valid=0): on acceptance, go to RESP.
  - RESP (resp_valid=1): if resp_ready and a new request is accepted, stay in RESP with the new data. If resp_ready and no request, go to IDLE. If !resp_ready, hold.
  - While resp_valid && !resp_ready, resp_rdata and resp_err stay stable.
- Latency: response appears exactly 1 cycle after acceptance. Back-to-back accepted requests give one response per cycle.
- Stores:
  - Byte enables are derived from size and addr[1:0]: byte gives 1<<addr[1:0]; half gives 0011 or 1100 selected by addr[1]; word gives 1111.
  - Write data is replicated into the enabled lanes.
  - Only enabled bytes are written, at the acceptance edge.
  - The response carries rdata=0.
- Loads:
  - The array is read at the acceptance edge into a registered word.
  - Lane selection uses the registered addr[1:0]/size/unsigned, followed by extension to 32 bits.
  - A load accepted in the cycle after a store to the same word returns the post-store data; there is no stale read.
- Misalignment:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - Without the optional feature, misaligned low address bits are forced to zero (aligned down) before lane selection.
- Reset mid-transaction: a pending response is dropped. A store accepted in the same cycle as rst high is NOT performed; rst masks acceptance.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned request is still accepted and responds with resp_err=1 and resp_rdata=0.
  - A misaligned store writes nothing.
  - Aligned accesses give resp_err=0.
- Not defined:
  - resp_err is tied to 0.
  - Misaligned accesses are aligned down as above, and stores write the aligned-down lanes.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - function computing the 4-bit byte enable from size and addr[1:0];
  - function extracting and extending a load lane from a 32-bit word.
- Sub-module: mem_array_be, a DEPTH_WORDS x 32 synchronous-read RAM with 4-bit byte write enable and zero initialisation.
- Handshake, state machine and lane logic stay in data_mem_ctrl.

Test Plan:
- Word store then load: store 0xDEADBEEF to 0x10, then load word from 0x10 -> resp_rdata=0xDEADBEEF, 1 cycle after acceptance, resp_err=0.
- Byte store and extension:
  - store byte 0x80 to 0x21 over a word of 0 -> word 0x00008000;
  - load byte signed from 0x21 -> 0xFFFFFF80;
  - load byte unsigned from 0x21 -> 0x00000080.
- Half access: store half 0xBEEF to 0x42 -> load word from 0x40 returns 0xBEEF0000; load half signed from 0x42 returns 0xFFFFBEEF.
- Backpressure: hold resp_ready=0 for 3 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0. Release -> response consumed and next request accepted in the same cycle.
- Misaligned word store of 0x12345678 to 0x05:
  - with MEM_MISALIGN_TRAP_EN -> resp_err=1 and word 0x04 unchanged;
  - without it -> word 0x04 becomes 0x12345678.
- Reset and alias:
  - assert rst while resp_valid=1 -> next cycle resp_valid=0 and RAM contents retained;
  - with DEPTH_WORDS=1024, a store to 0x1000 is read back from 0x0000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory: access size encodings plus lane/byte-enable helpers.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    // Aligns the low address bits down to the natural boundary of the access.
    function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return off;
            SZ_HALF: return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return {{24{~uns & b[7]}}, b};
            SZ_HALF: return {{16{~uns & h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/mem_array_be.sv
// DEPTH_WORDS x 32 synchronous-read RAM with per-byte write enables, built as four byte-wide lanes.
module mem_array_be #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rd_en,
    input  logic [3:0]                     wr_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            // Zero contents come from the elaboration-time initialiser; reset never touches the array.
            logic [7:0] lane_mem [DEPTH_WORDS] = '{default: 8'h00};
            logic [7:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (wr_be[gi]) lane_mem[addr] <= wdata[gi*8 +: 8];
                if (rd_en)     lane_q_reg     <= lane_mem[addr];
            end

            assign rdata[gi*8 +: 8] = lane_q_reg;
        end
    endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store data memory controller: valid/ready handshake, one outstanding response, byte/half/word lanes.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses answer with resp_err=1 instead of being aligned down.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic        load_reg;
    logic        uns_reg;
    logic [1:0]  size_reg;
    logic [1:0]  off_reg;

    logic        accept;
    logic        req_err;
    logic [1:0]  req_off_al;
    logic [3:0]  wr_be;
    logic [31:0] ram_rdata;

    assign req_ready  = !resp_valid_reg || resp_ready;
    // Reset masks acceptance so a store presented during reset never reaches the array.
    assign accept     = req_valid && req_ready && !rst;
    assign req_off_al = align_off(req_size, req_addr[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign req_err = is_misaligned(req_size, req_addr[1:0]);
`else
    assign req_err = 1'b0;
`endif

    assign wr_be = (accept && req_we && !req_err) ? byte_en(req_size, req_off_al) : 4'b0000;

    mem_array_be #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rd_en (accept && !req_we),
        .wr_be (wr_be),
        .addr  (req_addr[AW+1:2]),
        .wdata (wdata_rep(req_size, req_wdata)),
        .rdata (ram_rdata)
    );

    generate
        if (ADDR_W > AW + 2) begin : g_alias
            // Upper address bits alias onto the array.
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_W-1:AW+2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            load_reg       <= 1'b0;
            uns_reg        <= 1'b0;
            size_reg       <= SZ_WORD;
            off_reg        <= 2'b00;
        end else begin
            if (accept) begin
                load_reg     <= !req_we;
                uns_reg      <= req_unsigned;
                size_reg     <= req_size;
                off_reg      <= req_off_al;
                resp_err_reg <= req_err;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                    end
                end
                RESP: begin
                    if (!accept && resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    resp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Read word and lane metadata only change on acceptance, so the data holds under backpressure.
    assign resp_rdata = (resp_valid_reg && load_reg && !resp_err_reg)
                        ? load_extend(ram_rdata, size_reg, off_reg, uns_reg) : 32'h0;
    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expectations queued at acceptance, compared when responses appear.
module tb_data_mem_ctrl;
    import mem_pkg::*;

    localparam int DEPTH_WORDS = 1024;
    localparam int ADDR_W      = 32;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = SZ_WORD;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    data_mem_ctrl #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    int          ncyc = 0;
    int          acc_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_txn = 0;
    bit          shown = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Monitor: pops and compares the current response, then records any request accepted at the next edge.
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            sb.delete();
            shown = 1'b0;
        end else begin
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(resp_valid), 32'h0);
                end else begin
                    if (!shown) begin
                        check("latency", ncyc, sb[0].due);
                        shown = 1'b1;
                    end
                    check("rdata", resp_rdata, sb[0].rdata);
                    check("err", 32'(resp_err), 32'(sb[0].err));
                    if (resp_ready) begin
                        n_txn++;
                        $display("txn %0d: cycle %0d rdata=%08h err=%0b", n_txn, ncyc, resp_rdata, resp_err);
                        void'(sb.pop_front());
                        shown = 1'b0;
                    end
                end
            end
            if (req_valid && req_ready) begin
                sb.push_back('{exp_rdata, exp_err, ncyc + 1});
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
        int c0;
        int n;
        c0 = acc_cnt;
        n  = 0;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        exp_rdata = erd; exp_err = eerr; req_valid = 1'b1;
        do begin
            @(posedge clk);
            n++;
        end while (acc_cnt == c0 && n < 50);
        check("accept", 32'(acc_cnt != c0), 32'h1);
        #1 req_valid = 1'b0;
    endtask

    task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata, input logic eerr);
        send(1'b1, size, 1'b0, addr, wdata, 32'h0, eerr);
    endtask

    task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                      input logic [31:0] erd, input logic eerr);
        send(1'b0, size, uns, addr, 32'h0, erd, eerr);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;

        // Word store then back-to-back load of the same word
        st(SZ_WORD, 32'h10, 32'hDEADBEEF, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

        // Byte store into a zero word and both extensions
        st(SZ_BYTE, 32'h21, 32'h12345680, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h20, 32'h00008000, 1'b0);
        ld(SZ_BYTE, 1'b0, 32'h21, 32'hFFFFFF80, 1'b0);
        ld(SZ_BYTE, 1'b1, 32'h21, 32'h00000080, 1'b0);

        // Half store in the upper lane
        st(SZ_HALF, 32'h42, 32'h0000BEEF, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h40, 32'hBEEF0000, 1'b0);
        ld(SZ_HALF, 1'b0, 32'h42, 32'hFFFFBEEF, 1'b0);
        ld(SZ_HALF, 1'b1, 32'h42, 32'h0000BEEF, 1'b0);
        ld(2'b11, 1'b1, 32'h40, 32'hBEEF0000, 1'b0);

        // Every byte lane, then a positive signed byte
        for (int i = 0; i < 4; i++) st(SZ_BYTE, 32'h50 + i, 32'h11 * (i + 1), 1'b0);
        ld(SZ_WORD, 1'b0, 32'h50, 32'h44332211, 1'b0);
        ld(SZ_BYTE, 1'b0, 32'h53, 32'h00000044, 1'b0);
        drain();

        // Backpressure: stall three cycles with a second request waiting
        resp_ready = 1'b0;
        ld(SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        c0 = acc_cnt;
        req_we = 1'b0; req_size = SZ_HALF; req_unsigned = 1'b1; req_addr = 32'h42;
        exp_rdata = 32'h0000BEEF; exp_err = 1'b0; req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("bp_resp_valid", 32'(resp_valid), 32'h1);
            check("bp_req_ready", 32'(req_ready), 32'h0);
        end
        check("bp_no_accept", acc_cnt, c0);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("release_req_ready", 32'(req_ready), 32'h1);
        check("release_accept", acc_cnt, c0 + 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();

        // Misaligned word store and loads
        st(SZ_WORD, 32'h04, 32'hA5A5A5A5, 1'b0);
        st(SZ_WORD, 32'h05, 32'h12345678, TRAP);
        ld(SZ_WORD, 1'b0, 32'h04, TRAP ? 32'hA5A5A5A5 : 32'h12345678, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h06, TRAP ? 32'h0 : 32'h12345678, TRAP);
        ld(SZ_HALF, 1'b0, 32'h43, TRAP ? 32'h0 : 32'hFFFFBEEF, TRAP);

        // Address aliasing modulo 4*DEPTH_WORDS
        st(SZ_WORD, 32'h1000, 32'hCAFEF00D, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h0000, 32'hCAFEF00D, 1'b0);
        drain();

        // Reset drops a stalled response
        resp_ready = 1'b0;
        ld(SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_resp_valid", 32'(resp_valid), 32'h0);
        check("midrst_resp_rdata", resp_rdata, 32'h0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;

        // A store presented during reset is masked; RAM keeps its contents
        rst = 1'b1;
        req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h10; req_wdata = 32'hBAD0BAD0; req_valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        ld(SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        ld(SZ_WORD, 1'b0, 32'h50, 32'h44332211, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
